// File: rtl/ysyx_22040759_axi_wr_master_pkg.sv
// Shared encodings and types for the AXI4 write master.
// Holds burst/resp/prot/cache codes, store sizes and the FSM state enum.
package ysyx_22040759_axi_wr_master_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;
    localparam logic [3:0] CACHE_DEV_NB = 4'b0000;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } wr_state_t;

endpackage

// File: rtl/ysyx_22040759_axi_wr_master_if.sv
// AXI4 write-channel bundle (AW, W, B).
// master: drives AW/W payload + valids and bready; slave: the reverse.
interface ysyx_22040759_axi_wr_master_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                          awvalid;
    logic                          awready;
    logic [AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [AXI_ID_WIDTH-1:0]       awid;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic [2:0]                    awprot;
    logic [3:0]                    awcache;
    logic                          awlock;
    logic [3:0]                    awqos;
    logic [0:0]                    awuser;
    logic                          wvalid;
    logic                          wready;
    logic [AXI_DATA_WIDTH-1:0]     wdata;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                          wlast;
    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;
    logic [AXI_ID_WIDTH-1:0]       bid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output awprot, awcache, awlock, awqos, awuser,
        output wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awprot, awcache, awlock, awqos, awuser,
        input  wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/ysyx_22040759_wstrb_gen.sv
// Byte-lane generator for single (possibly bus-straddling) accesses.
// In: i_off, i_size, i_beat. Out: o_shift (bits), o_wstrb, o_cross.
module ysyx_22040759_wstrb_gen #(
    parameter  int AXI_DATA_WIDTH = 64,
    localparam int B     = AXI_DATA_WIDTH / 8,
    localparam int ALIGN = $clog2(B)
) (
    input  logic [ALIGN-1:0] i_off,
    input  logic [2:0]       i_size,
    input  logic             i_beat,
    output logic [ALIGN+2:0] o_shift,
    output logic [B-1:0]     o_wstrb,
    output logic             o_cross
);
    logic [7:0]     w_nb;
    logic [2*B-1:0] w_mask;
    logic [2*B-1:0] w_full;
    logic [8:0]     w_end;

    assign w_nb   = 8'd1 << i_size;
    assign w_mask = ~({(2*B){1'b1}} << w_nb);
    // The upper half of the double-width strobe is the second beat.
    assign w_full  = w_mask << i_off;
    assign o_wstrb = i_beat ? w_full[2*B-1:B] : w_full[B-1:0];
    assign w_end   = {{(9-ALIGN){1'b0}}, i_off} + {1'b0, w_nb};
    assign o_cross = w_end > 9'(B);
    assign o_shift = {i_off, 3'b000};
endmodule

// File: rtl/ysyx_22040759_axi_wr_master.sv
// AXI4 write master: single stores (auto-split when straddling) or line bursts.
// Ports: clk/rst, req_* request latch, done_o/err_o, axi (master modport).
module ysyx_22040759_axi_wr_master
    import ysyx_22040759_axi_wr_master_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0,
    parameter int LINE_BEATS     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]            req_addr_i,
    input  logic [2:0]                           req_size_i,
    input  logic                                 req_line_i,
    input  logic [AXI_DATA_WIDTH-1:0]            req_data_i,
    input  logic [LINE_BEATS*AXI_DATA_WIDTH-1:0] req_line_data_i,
    output logic                                 done_o,
    output logic                                 err_o,
    ysyx_22040759_axi_wr_master_if.master        axi
);
    localparam int DW     = AXI_DATA_WIDTH;
    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int B      = DW / 8;
    localparam int ALIGN  = $clog2(B);
    localparam int LBW    = $clog2(LINE_BEATS);
    localparam int LALIGN = ALIGN + LBW;

    wr_state_t                        r_state;
    wr_state_t                        w_next;
    logic [AW-1:0]                    r_addr;
    logic [2:0]                       r_size;
    logic                             r_line;
    logic [DW-1:0]                    r_data;
    logic [LINE_BEATS-1:0][DW-1:0]    r_ldata;
    logic [7:0]                       r_cnt;
    logic                             r_done;
    logic                             r_err;

    logic             w_accept;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_awvalid;
    logic             w_wvalid;
    logic             w_bready;
    logic             w_last;
    logic             w_cross;
    logic [7:0]       w_awlen;
    logic [ALIGN+2:0] w_shift;
    logic [B-1:0]     w_sstrb;
    logic [2*DW-1:0]  w_wide;
    logic [DW-1:0]    w_sdata;
    logic             w_unused_bid;

    assign req_ready_o = (r_state == ST_IDLE) & ~rst;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_w_hs      = w_wvalid & axi.wready;
    assign w_b_hs      = w_bready & axi.bvalid;

    ysyx_22040759_wstrb_gen #(.AXI_DATA_WIDTH(DW)) u_strb (
        .i_off   (r_addr[ALIGN-1:0]),
        .i_size  (r_size),
        .i_beat  (r_cnt[0]),
        .o_shift (w_shift),
        .o_wstrb (w_sstrb),
        .o_cross (w_cross)
    );

    assign w_awlen = r_line ? 8'(LINE_BEATS - 1) : {7'd0, w_cross};
    assign w_last  = (r_cnt == w_awlen);
    // Straddling store: low half is beat 0, high half is beat 1.
    assign w_wide  = {{DW{1'b0}}, r_data} << w_shift;
    assign w_sdata = r_cnt[0] ? w_wide[2*DW-1:DW] : w_wide[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_AW;
            ST_AW: begin
                w_awvalid = 1'b1;
                if (axi.awready) w_next = ST_W;
            end
            ST_W: begin
                w_wvalid = 1'b1;
                if (axi.wready && w_last) w_next = ST_B;
            end
            ST_B: begin
                w_bready = 1'b1;
                if (axi.bvalid) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 8'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_b_hs;
            r_err  <= w_b_hs & (axi.bresp != RESP_OKAY);
            if (w_accept)    r_cnt <= 8'd0;
            else if (w_w_hs) r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= req_addr_i;
            r_size  <= req_size_i;
            r_line  <= req_line_i;
            r_data  <= req_data_i;
            r_ldata <= req_line_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept)
            assert (req_size_i <= 3'(ALIGN));
    end

    assign done_o = r_done;
    assign err_o  = r_err;

    assign axi.awvalid = w_awvalid;
    assign axi.awaddr  = r_line ? {r_addr[AW-1:LALIGN], {LALIGN{1'b0}}}
                                : {r_addr[AW-1:ALIGN], {ALIGN{1'b0}}};
    assign axi.awid    = AXI_ID_WIDTH'(AXI_ID);
    assign axi.awlen   = w_awlen;
    assign axi.awsize  = 3'(ALIGN);
    assign axi.awburst = BURST_INCR;
    assign axi.awprot  = PROT_DEFAULT;
    assign axi.awcache = CACHE_DEV_NB;
    assign axi.awlock  = 1'b0;
    assign axi.awqos   = 4'd0;
    assign axi.awuser  = 1'b0;
    assign axi.wvalid  = w_wvalid;
    assign axi.wdata   = r_line ? r_ldata[r_cnt[LBW-1:0]] : w_sdata;
    assign axi.wstrb   = r_line ? {B{1'b1}} : w_sstrb;
    assign axi.wlast   = w_last;
    assign axi.bready  = w_bready;

    assign w_unused_bid = ^axi.bid;
endmodule

// File: tb/tb_ysyx_22040759_axi_wr_master.sv
// Scoreboard bench for the AXI4 write master.
// Directed stores/line bursts with a simple AXI slave model.
module tb_ysyx_22040759_axi_wr_master;
    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [2:0]   req_size;
    logic         req_line;
    logic [63:0]  req_data;
    logic [255:0] req_ldata;
    logic         done;
    logic         err;

    ysyx_22040759_axi_wr_master_if #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)
    ) axi ();

    ysyx_22040759_axi_wr_master #(
        .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4),
        .AXI_ID(0), .LINE_BEATS(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_size_i      (req_size),
        .req_line_i      (req_line),
        .req_data_i      (req_data),
        .req_line_data_i (req_ldata),
        .done_o          (done),
        .err_o           (err),
        .axi             (axi.master)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_exp_t;

    typedef struct {
        logic err;
        int   acc;
        int   lat;
    } d_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    d_exp_t  d_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        wtoggle = 1'b0;
    logic [1:0]  bresp_sel = 2'b00;
    logic        s_hs_w = 1'b0;
    logic        s_hs_b = 1'b0;
    logic        hold_pend = 1'b0;
    logic [72:0] hold_val = '0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave: zero-wait AW, optional toggling wready, B one cycle after wlast.
    always @(negedge clk) begin
        s_hs_w = axi.wvalid && axi.wready && axi.wlast;
        s_hs_b = axi.bvalid && axi.bready;
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            axi.bvalid = 1'b0;
        end else begin
            if (s_hs_b) axi.bvalid = 1'b0;
            if (s_hs_w) begin
                axi.bvalid = 1'b1;
                axi.bresp  = bresp_sel;
            end
        end
        axi.wready = wtoggle ? ~axi.wready : 1'b1;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (axi.awvalid || axi.wvalid)
            chk("aw_w_exclusive", 1'(axi.awvalid && axi.wvalid), 0);
        if (err && !done)
            chk("err_without_done", err, 0);

        if (axi.awvalid && axi.awready) begin
            if (aw_q.size() == 0) begin
                chk("aw_unexpected", 1, 0);
            end else begin
                aw_exp_t e;
                e = aw_q.pop_front();
                chk("aw", {axi.awaddr, axi.awlen, axi.awsize,
                           axi.awburst, axi.awprot, axi.awcache,
                           axi.awlock, axi.awqos, axi.awuser, axi.awid},
                    {e.addr, e.len, 3'd3, 2'b01, 3'd0, 4'd0,
                     1'b0, 4'd0, 1'b0, 4'd0});
            end
        end

        if (hold_pend && axi.wvalid)
            chk("w_hold", {axi.wdata, axi.wstrb, axi.wlast}, hold_val);
        hold_pend = axi.wvalid && !axi.wready && !rst;
        hold_val  = {axi.wdata, axi.wstrb, axi.wlast};

        if (axi.wvalid && axi.wready) begin
            if (w_q.size() == 0) begin
                chk("w_unexpected", 1, 0);
            end else begin
                w_exp_t e;
                e = w_q.pop_front();
                chk("w_beat", {axi.wdata, axi.wstrb, axi.wlast},
                    {e.data, e.strb, e.last});
            end
        end

        if (done) begin
            if (d_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                d_exp_t e;
                e = d_q.pop_front();
                chk("done_err", err, e.err);
                if (e.lat >= 0)
                    chk("done_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [2:0] s,
                         input logic l, input logic [63:0] d,
                         input logic [255:0] ld, output int acc);
        req_addr  = a;
        req_size  = s;
        req_line  = l;
        req_data  = d;
        req_ldata = ld;
        req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Scramble the inputs: the outputs must come from the latch.
        req_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_addr  = 32'h1234_5677;
        req_size  = 3'd0;
        req_line  = ~l;
        req_ldata = '1;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (aw_q.size() == 0 && w_q.size() == 0 && d_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("completion_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_aw(input logic [31:0] a, input logic [7:0] l);
        aw_exp_t e;
        e.addr = a;
        e.len  = l;
        aw_q.push_back(e);
    endtask

    task automatic push_w(input logic [63:0] d, input logic [7:0] s,
                          input logic l);
        w_exp_t e;
        e.data = d;
        e.strb = s;
        e.last = l;
        w_q.push_back(e);
    endtask

    task automatic push_d(input logic e_err, input int acc, input int lat);
        d_exp_t e;
        e.err = e_err;
        e.acc = acc;
        e.lat = lat;
        d_q.push_back(e);
    endtask

    int acc;
    int acc5;
    logic [255:0] line0;
    logic [255:0] line1;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_line   = 1'b0;
        req_data   = '0;
        req_ldata  = '0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {req_ready, axi.awvalid, axi.wvalid,
                              axi.bready, done, err}, 6'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // sd aligned
        push_aw(32'h8000_0008, 8'd0);
        push_w(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        issue(32'h8000_0008, 3'd3, 1'b0, 64'h1122_3344_5566_7788, '0, acc);
        push_d(1'b0, acc, 4);
        wait_idle();

        // sb at offset 3
        push_aw(32'h8000_0000, 8'd0);
        push_w(64'h0000_0000_AB00_0000, 8'h08, 1'b1);
        issue(32'h8000_0003, 3'd0, 1'b0, 64'h0000_0000_0000_00AB, '0, acc);
        push_d(1'b0, acc, 4);
        wait_idle();

        // sw at offset 6 straddles: two beats
        push_aw(32'h8000_0000, 8'd1);
        push_w(64'hBEEF_0000_0000_0000, 8'hC0, 1'b0);
        push_w(64'h0000_0000_0000_DEAD, 8'h03, 1'b1);
        issue(32'h8000_0006, 3'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, '0, acc);
        push_d(1'b0, acc, 5);
        wait_idle();

        // line burst with wready toggling
        line0 = {64'h4444_4444_4444_4404, 64'h3333_3333_3333_3303,
                 64'h2222_2222_2222_2202, 64'h1111_1111_1111_1101};
        wtoggle = 1'b1;
        push_aw(32'h8000_0020, 8'd3);
        push_w(64'h1111_1111_1111_1101, 8'hFF, 1'b0);
        push_w(64'h2222_2222_2222_2202, 8'hFF, 1'b0);
        push_w(64'h3333_3333_3333_3303, 8'hFF, 1'b0);
        push_w(64'h4444_4444_4444_4404, 8'hFF, 1'b1);
        issue(32'h8000_0038, 3'd3, 1'b1, '0, line0, acc);
        push_d(1'b0, acc, -1);
        wait_idle();
        wtoggle = 1'b0;
        @(posedge clk);
        #1;

        // sh with SLVERR, then a request accepted in the done cycle
        bresp_sel = 2'b10;
        push_aw(32'h8000_0000, 8'd0);
        push_w(64'h0000_0000_5A5A_0000, 8'h0C, 1'b1);
        issue(32'h8000_0002, 3'd1, 1'b0, 64'h0000_0000_0000_5A5A, '0, acc5);
        push_d(1'b1, acc5, 4);
        push_aw(32'h8000_0010, 8'd0);
        push_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        issue(32'h8000_0010, 3'd3, 1'b0, 64'h0123_4567_89AB_CDEF, '0, acc);
        bresp_sel = 2'b00;
        chk("accept_in_done_cycle", acc, acc5 + 4);
        push_d(1'b0, acc, 4);
        wait_idle();
        @(negedge clk);
        chk("err_cleared", {done, err}, 2'b00);
        @(posedge clk);
        #1;

        // reset in the middle of a line burst (after beat 1)
        line1 = {64'hDDDD_0000_0000_0003, 64'hCCCC_0000_0000_0002,
                 64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        push_aw(32'h8000_0000, 8'd3);
        push_w(64'hAAAA_0000_0000_0000, 8'hFF, 1'b0);
        push_w(64'hBBBB_0000_0000_0001, 8'hFF, 1'b0);
        push_w(64'hCCCC_0000_0000_0002, 8'hFF, 1'b0);
        push_w(64'hDDDD_0000_0000_0003, 8'hFF, 1'b1);
        issue(32'h8000_0000, 3'd3, 1'b1, '0, line1, acc);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_valids", {axi.awvalid, axi.wvalid, axi.bready, done},
            4'b0000);
        chk("abort_beats_left", w_q.size(), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        w_q.delete();
        @(negedge clk);
        chk("abort_idle", req_ready, 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;

        // fresh sd after abort
        push_aw(32'h8000_0018, 8'd0);
        push_w(64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1);
        issue(32'h8000_0018, 3'd3, 1'b0, 64'hCAFE_F00D_1234_5678, '0, acc);
        push_d(1'b0, acc, 4);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22040759_axi_wr_master.md
# ysyx_22040759_axi_wr_master

AXI4 write master for the LSU store path and the D-cache write-back path. Accepts one latched request at a time: either a single store (byte/half/word/double, any alignment) or a full cache-line burst. Unaligned stores that straddle a data-bus boundary are automatically split into a 2-beat INCR burst. Completion is reported with a one-cycle done pulse carrying the B-channel error status.

## Interface
- AXI_DATA_WIDTH, 64: W data width; power of two, 32 or 64.
- AXI_ADDR_WIDTH, 32: AW address width.
- AXI_ID_WIDTH, 4: ID width; awid driven to AXI_ID.
- AXI_ID, 0: constant transaction ID.
- LINE_BEATS, 4: beats per line burst; power of two, 2..16.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- req_addr_i  in  AXI_ADDR_WIDTH  byte address.
- req_size_i  in  3  log2 bytes, 0..log2(AXI_DATA_WIDTH/8).
- req_line_i  in  1  1 = line burst, 0 = single store.
- req_data_i  in  AXI_DATA_WIDTH  store data, LSB-justified.
- req_line_data_i  in  LINE_BEATS*AXI_DATA_WIDTH  line data; beat k = slice k.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o; 1 if bresp != OKAY.
- AW channel: awvalid out, awready in, awaddr, awid, awlen[7:0], awsize[2:0], awburst[1:0], awprot[2:0], awcache[3:0], awlock, awqos[3:0], awuser[0:0].
- W channel: wvalid out, wready in, wdata, wstrb[AXI_DATA_WIDTH/8], wlast.
- B channel: bvalid in, bready out, bresp[1:0] in, bid in (ignored).

## Operation
- Accept on req_valid_i & req_ready_o. Latch addr, size, mode, and data into registers. AXI outputs never depend on live req_* inputs.
- States: IDLE -> AW (on accept) -> W (on aw handshake) -> B (on w handshake with wlast) -> IDLE (on b handshake). No other transitions; the default state goes to IDLE.
- Constants: awburst = INCR, awsize = log2(AXI_DATA_WIDTH/8), awcache = 0000, awprot = 000, awlock = 0, awqos = 0, awuser = 0.
- Single store, with off = addr[ALIGN-1:0], nb = 1<<size, B = AXI_DATA_WIDTH/8:
  - awaddr = addr aligned down to B.
  - cross = (off + nb > B); awlen = cross.
  - Beat 0: wdata = data << 8*off; wstrb = ((1<<nb)-1) << off, truncated to B bits.
  - Beat 1 (only if cross): wdata = data >> 8*(B-off); wstrb = ((1<<nb)-1) >> (B-off).
- Line burst:
  - awaddr = addr aligned down to LINE_BEATS*B; awlen = LINE_BEATS-1.
  - wstrb = all ones; beat k drives latched slice k.
- Beat counter: cleared on accept, incremented on each w handshake. wlast = (cnt == awlen).
- bready is high only in B. On the b handshake, capture err = (bresp != 2'b00).
- req_size_i > log2(B) is illegal; this is a simulation assertion only.

## Timing
- Reset values: req_ready_o=0 during reset then 1 in IDLE; awvalid, wvalid, bready, done_o, err_o, and cnt all 0; state IDLE.
- Accept in cycle 0; awvalid in cycle 1. With zero-wait slaves:
  - First wvalid is in cycle 2; beats are back-to-back.
  - bready rises the cycle after wlast.
  - done_o fires the cycle after the b handshake, together with req_ready_o.
- Minimum latency from accept to done_o: 4 + awlen cycles.
- valid/data/strb/last are held stable until their ready arrives. Slave back-pressure on any channel stalls in place.
- awvalid and wvalid are never high together (strict AW-before-W ordering).
- Reset asserted mid-transaction: state goes to IDLE and all valids drop in the next cycle. No done_o is produced for the aborted request.
- A new request can be accepted in the same cycle done_o is high.

## Structure
- Shared package holds:
  - burst/resp/prot/cache encodings (INCR, OKAY, ...);
  - SIZE_B/H/W/D;
  - the state enum {IDLE, AW, W, B}.
- Sub-module ysyx_22040759_wstrb_gen: combinational (off, size, beat) -> (shift, wstrb, cross) for single stores. It is shared with the future read master's byte-lane extraction.
- The top module holds the FSM, the request latch, and the beat counter.

## Test plan
- sd at 0x8000_0008, data 0x1122334455667788, zero-wait slave -> awaddr=0x8000_0008, awlen=0, wstrb=0xFF, done_o 4 cycles after accept, err_o=0.
- sb at 0x8000_0003, data 0xAB -> wstrb=0x08, wdata[31:24]=0xAB.
- sw at 0x8000_0006, data 0xDEADBEEF -> awlen=1; beat0 wstrb=0xC0, wdata[63:48]=0xBEEF; beat1 wstrb=0x03, wdata[15:0]=0xDEAD; wlast only on beat1.
- Line write at 0x8000_0038 (LINE_BEATS=4) -> awaddr=0x8000_0020, awlen=3, 4 beats in slice order, wlast on beat 3. With wready toggling every other cycle, data is held and done_o follows.
- bresp=SLVERR on a single store -> done_o=1, err_o=1 for exactly one cycle; the next request is accepted in that same cycle.
- rst asserted while in W after beat 1 of a line burst -> wvalid=0 the next cycle, state IDLE, no done_o. A fresh sd then completes normally.
